// File: rtl/game_pkg.sv
// Shared game types and constants: FSM encoding, datapath widths and sprite timing.
package game_pkg;

  localparam int unsigned SCORE_W = 16;
  localparam int unsigned FRAME_W = 12;
  localparam int unsigned LIVES_W = 2;
  localparam int unsigned OVL_W   = 8;
  localparam int unsigned INV_W   = 12;

  // Screen and sprite geometry consumed by the sprite layer.
  localparam int unsigned GAME_H_ACTIVE = 640;
  localparam int unsigned GAME_V_ACTIVE = 480;
  localparam int unsigned GAME_SPRITE_W = 32;
  localparam int unsigned GAME_SPRITE_H = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PLAY     = 3'd1,
    ST_HIT      = 3'd2,
    ST_DEAD     = 3'd3,
    ST_FINISHED = 3'd4
  } game_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/game_state_ctrl.sv
// Per-frame collision, lives, score and run-time controller driving sprite status flags.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LIVES          = 3,
  parameter int unsigned COLLIDE_THRESH = 16,
  parameter int unsigned INVULN_FRAMES  = 120,
  parameter int unsigned FINISH_FRAMES  = 3600,
  parameter int unsigned CRUSH_POINTS   = 10
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_v_sync,
  input  logic               i_start,
  input  logic               i_penguin_hit,
  input  logic               i_obstacle_hit_left,
  input  logic               i_obstacle_hit_right,
  input  logic               i_crushed_left,
  input  logic               i_crushed_right,
  output logic               o_is_dead,
  output logic               o_is_finished,
  output logic               o_invuln,
  output logic [LIVES_W-1:0] o_lives,
  output logic [SCORE_W-1:0] o_score,
  output logic [FRAME_W-1:0] o_frames_left,
  output logic [2:0]         o_state
);

  localparam int unsigned SUM_W = SCORE_W + 1;

  game_state_e        r_state;
  logic [LIVES_W-1:0] r_lives;
  logic [SCORE_W-1:0] r_score;
  logic [FRAME_W-1:0] r_frames_left;
  logic [OVL_W-1:0]   r_ovl_cnt;
  logic [INV_W-1:0]   r_inv_cnt;
  logic               r_is_dead;
  logic               r_is_finished;
  logic               r_invuln;

  game_state_e        w_state_nxt;
  logic [LIVES_W-1:0] w_lives_nxt;
  logic [SCORE_W-1:0] w_score_nxt;
  logic [FRAME_W-1:0] w_frames_nxt;
  logic [OVL_W-1:0]   w_ovl_nxt;
  logic [INV_W-1:0]   w_inv_nxt;
  logic               w_frame;
  logic               w_crush_l;
  logic               w_crush_r;
  logic               w_active;
  logic               w_overlap;
  logic               w_collide;
  logic               w_fatal;
  logic [1:0]         w_crush_n;
  logic [SUM_W-1:0]   w_score_sum;

  sync_edge u_sync_vsync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_v_sync),
    .o_rise  (w_frame)
  );

  sync_edge u_sync_crush_l (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_crushed_left),
    .o_rise  (w_crush_l)
  );

  sync_edge u_sync_crush_r (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_crushed_right),
    .o_rise  (w_crush_r)
  );

  // Next-state and datapath decisions; a frame event closes the current frame.
  always_comb begin
    w_state_nxt  = r_state;
    w_lives_nxt  = r_lives;
    w_score_nxt  = r_score;
    w_frames_nxt = r_frames_left;
    w_ovl_nxt    = r_ovl_cnt;
    w_inv_nxt    = r_inv_cnt;

    w_active    = (r_state == ST_PLAY) || (r_state == ST_HIT);
    w_overlap   = i_penguin_hit & (i_obstacle_hit_left | i_obstacle_hit_right);
    w_collide   = (r_state == ST_PLAY) && (32'(r_ovl_cnt) >= COLLIDE_THRESH);
    w_fatal     = w_frame && w_collide && (r_lives <= LIVES_W'(1));
    w_crush_n   = {1'b0, w_crush_l} + {1'b0, w_crush_r};
    w_score_sum = SUM_W'(r_score) + SUM_W'(w_crush_n) * SUM_W'(CRUSH_POINTS);

    if (!w_active) begin
      if (i_start) begin
        w_state_nxt  = ST_PLAY;
        w_lives_nxt  = LIVES_W'(LIVES);
        w_score_nxt  = '0;
        w_frames_nxt = FRAME_W'(FINISH_FRAMES);
        w_ovl_nxt    = '0;
        w_inv_nxt    = '0;
      end
    end else begin
      if (w_overlap && (r_ovl_cnt != '1)) begin
        w_ovl_nxt = r_ovl_cnt + OVL_W'(1);
      end

      if (w_frame) begin
        // Overlap on the event cycle belongs to the frame that is starting.
        w_ovl_nxt    = w_overlap ? OVL_W'(1) : '0;
        w_frames_nxt = (r_frames_left == '0) ? '0 : r_frames_left - FRAME_W'(1);
        if (w_collide) begin
          if (r_lives <= LIVES_W'(1)) begin
            w_lives_nxt = '0;
            w_state_nxt = ST_DEAD;
          end else begin
            w_lives_nxt = r_lives - LIVES_W'(1);
            w_state_nxt = ST_HIT;
            w_inv_nxt   = INV_W'(INVULN_FRAMES);
          end
        end else if (r_state == ST_HIT) begin
          if (r_inv_cnt <= INV_W'(1)) begin
            w_inv_nxt   = '0;
            w_state_nxt = ST_PLAY;
          end else begin
            w_inv_nxt = r_inv_cnt - INV_W'(1);
          end
        end
        if (!w_fatal && (w_frames_nxt == '0)) begin
          w_state_nxt = ST_FINISHED;
        end
      end

      if (!w_fatal && (w_crush_n != 2'd0)) begin
        w_score_nxt = w_score_sum[SUM_W-1] ? '1 : w_score_sum[SCORE_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_lives       <= LIVES_W'(LIVES);
      r_score       <= '0;
      r_frames_left <= FRAME_W'(FINISH_FRAMES);
      r_ovl_cnt     <= '0;
      r_inv_cnt     <= '0;
      r_is_dead     <= 1'b0;
      r_is_finished <= 1'b0;
      r_invuln      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_lives       <= w_lives_nxt;
      r_score       <= w_score_nxt;
      r_frames_left <= w_frames_nxt;
      r_ovl_cnt     <= w_ovl_nxt;
      r_inv_cnt     <= w_inv_nxt;
      r_is_dead     <= (w_state_nxt == ST_DEAD);
      r_is_finished <= (w_state_nxt == ST_FINISHED);
      r_invuln      <= (w_state_nxt == ST_HIT);
    end
  end

  assign o_is_dead     = r_is_dead;
  assign o_is_finished = r_is_finished;
  assign o_invuln      = r_invuln;
  assign o_lives       = r_lives;
  assign o_score       = r_score;
  assign o_frames_left = r_frames_left;
  assign o_state       = r_state;

endmodule
